// File: rtl/bayer_demosaic.sv
// Bayer CFA demosaic: 3x3 window from two line buffers, selectable 2x2 or
// bilinear interpolation, border-cropped output with a fixed two-clock latency.
module bayer_demosaic #(
   parameter int DATA_SIZE  = 10,
   parameter int LINE_WIDTH = 640
) (
   input  logic                 iCLK,
   input  logic                 iRST_N,
   input  logic [DATA_SIZE-1:0] iData,
   input  logic                 iDval,
   input  logic                 iSOF,
   input  logic [1:0]           iPattern,
   input  logic                 iMode,
   output logic [DATA_SIZE-1:0] oRed,
   output logic [DATA_SIZE-1:0] oGreen,
   output logic [DATA_SIZE-1:0] oBlue,
   output logic                 oDval,
   output logic                 oSOF
);
   localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int SW = DATA_SIZE + 2;

   logic [XW-1:0]        x_q, x_d, px_s;
   logic [15:0]          y_q, y_d, py_s;
   logic                 started_q, started_d;
   logic [1:0]           pat_q, pat_d;
   logic                 mode_q, mode_d;
   logic                 v1_q, v1_d, sof1_q, sof1_d, m1_q, m1_d;
   logic [1:0]           site_q, site_d;
   logic [DATA_SIZE-1:0] win_q [3][3];
   logic [DATA_SIZE-1:0] lb1_q [LINE_WIDTH];
   logic [DATA_SIZE-1:0] lb2_q [LINE_WIDTH];
   logic [DATA_SIZE-1:0] r_s, g_s, b_s;
   logic [SW-1:0]        cross_s, diag_s, ew_s, ns_s, es_s, cse_s;

   // Beat position, counter advance, frame latches and stage-1 control
   always_comb begin
      px_s      = iSOF ? '0 : x_q;
      py_s      = iSOF ? 16'd0 : y_q;
      x_d       = x_q;
      y_d       = y_q;
      started_d = started_q;
      pat_d     = pat_q;
      mode_d    = mode_q;
      if (iDval) begin
         if (iSOF) begin
            started_d = 1'b1;
            pat_d     = iPattern;
            mode_d    = iMode;
         end else begin
            started_d = started_q;
         end
         if (px_s == XW'(LINE_WIDTH - 1)) begin
            x_d = '0;
            y_d = (py_s == 16'hFFFF) ? py_s : py_s + 16'd1;
         end else begin
            x_d = px_s + XW'(1);
            y_d = py_s;
         end
      end else begin
         x_d = x_q;
      end
      v1_d   = iDval && !iSOF && started_q && (x_q >= XW'(2)) && (y_q >= 16'd2);
      sof1_d = v1_d && (x_q == XW'(2)) && (y_q == 16'd2);
      // Centre sits at (X-1,Y-1), so its parity is the inverse of the beat's
      site_d = {~y_q[0] ^ pat_q[1], ~x_q[0] ^ pat_q[0]};
      m1_d   = mode_q;
   end

   // Counters, frame latches and the stage-1 pipeline register
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         x_q       <= '0;
         y_q       <= 16'd0;
         started_q <= 1'b0;
         pat_q     <= 2'b00;
         mode_q    <= 1'b1;
         v1_q      <= 1'b0;
         sof1_q    <= 1'b0;
         site_q    <= 2'b00;
         m1_q      <= 1'b1;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         started_q <= started_d;
         pat_q     <= pat_d;
         mode_q    <= mode_d;
         v1_q      <= v1_d;
         sof1_q    <= sof1_d;
         site_q    <= site_d;
         m1_q      <= m1_d;
      end
   end

   // Line buffers hold the two previous rows; contents are deliberately unreset
   always_ff @(posedge iCLK) begin
      if (iDval) begin
         lb1_q[px_s] <= iData;
         lb2_q[px_s] <= lb1_q[px_s];
      end
   end

   // 3x3 window shifts left by one column per accepted beat
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_q[r][c] <= '0;
      end else if (iDval) begin
         for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
         end
         win_q[0][2] <= lb2_q[px_s];
         win_q[1][2] <= lb1_q[px_s];
         win_q[2][2] <= iData;
      end
   end

   // Neighbour sums, wide enough that four full-scale samples cannot overflow
   always_comb begin
      cross_s = {2'b00, win_q[0][1]} + {2'b00, win_q[2][1]}
              + {2'b00, win_q[1][0]} + {2'b00, win_q[1][2]};
      diag_s  = {2'b00, win_q[0][0]} + {2'b00, win_q[0][2]}
              + {2'b00, win_q[2][0]} + {2'b00, win_q[2][2]};
      ew_s    = {2'b00, win_q[1][0]} + {2'b00, win_q[1][2]};
      ns_s    = {2'b00, win_q[0][1]} + {2'b00, win_q[2][1]};
      es_s    = {2'b00, win_q[1][2]} + {2'b00, win_q[2][1]};
      cse_s   = {2'b00, win_q[1][1]} + {2'b00, win_q[2][2]};
   end

   // Channel selection: {mode, site} where site 00=R, 01=G on R row, 10=G on B row, 11=B
   always_comb begin
      r_s = '0;
      g_s = '0;
      b_s = '0;
      case ({m1_q, site_q})
         3'b100: begin r_s = win_q[1][1]; g_s = cross_s[SW-1:2]; b_s = diag_s[SW-1:2]; end
         3'b111: begin b_s = win_q[1][1]; g_s = cross_s[SW-1:2]; r_s = diag_s[SW-1:2]; end
         3'b101: begin g_s = win_q[1][1]; r_s = ew_s[DATA_SIZE:1]; b_s = ns_s[DATA_SIZE:1]; end
         3'b110: begin g_s = win_q[1][1]; b_s = ew_s[DATA_SIZE:1]; r_s = ns_s[DATA_SIZE:1]; end
         3'b000: begin r_s = win_q[1][1]; g_s = es_s[DATA_SIZE:1]; b_s = win_q[2][2]; end
         3'b011: begin b_s = win_q[1][1]; g_s = es_s[DATA_SIZE:1]; r_s = win_q[2][2]; end
         3'b001: begin r_s = win_q[1][2]; g_s = cse_s[DATA_SIZE:1]; b_s = win_q[2][1]; end
         3'b010: begin b_s = win_q[1][2]; g_s = cse_s[DATA_SIZE:1]; r_s = win_q[2][1]; end
         default: begin r_s = '0; g_s = '0; b_s = '0; end
      endcase
   end

   // Output registers: colours hold between pulses, valid flags are single-cycle
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oRed   <= '0;
         oGreen <= '0;
         oBlue  <= '0;
         oDval  <= 1'b0;
         oSOF   <= 1'b0;
      end else begin
         if (v1_q) begin
            oRed   <= r_s;
            oGreen <= g_s;
            oBlue  <= b_s;
         end else begin
            oRed   <= oRed;
            oGreen <= oGreen;
            oBlue  <= oBlue;
         end
         oDval <= v1_q;
         oSOF  <= sof1_q;
      end
   end
endmodule

// File: tb/tb_bayer_demosaic.sv
// Directed bench for bayer_demosaic with an 8-pixel line and 6-row frames.
module tb_bayer_demosaic;
   localparam int DS = 10;
   localparam int LW = 8;

   logic          iCLK = 1'b0;
   logic          iRST_N;
   logic [DS-1:0] iData;
   logic          iDval, iSOF, iMode;
   logic [1:0]    iPattern;
   logic [DS-1:0] oRed, oGreen, oBlue;
   logic          oDval, oSOF;

   int tests = 0;
   int fails = 0;

   logic [DS-1:0] qr[$], qg[$], qb[$];
   logic          qs[$];

   bayer_demosaic #(.DATA_SIZE(DS), .LINE_WIDTH(LW)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iData(iData), .iDval(iDval), .iSOF(iSOF),
      .iPattern(iPattern), .iMode(iMode), .oRed(oRed), .oGreen(oGreen),
      .oBlue(oBlue), .oDval(oDval), .oSOF(oSOF));

   always #5 iCLK = ~iCLK;

   // Record every output pulse mid-cycle
   always @(negedge iCLK) begin
      if (oDval === 1'b1) begin
         qr.push_back(oRed);
         qg.push_back(oGreen);
         qb.push_back(oBlue);
         qs.push_back(oSOF);
      end
   end

   function automatic int pix(input int kind, input int flat, input int x, input int y);
      if (kind == 0) return flat;
      if (kind == 1) begin
         if ((y % 2 == 0) && (x % 2 == 0)) return 400;
         if ((y % 2 == 1) && (x % 2 == 1)) return 50;
         return 200;
      end
      return 10 * x + 100 * y + 5;
   endfunction

   task automatic clear_q();
      qr.delete(); qg.delete(); qb.delete(); qs.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   task automatic beat(input int d, input bit sof);
      iData = d[DS-1:0];
      iDval = 1'b1;
      iSOF  = sof;
      @(posedge iCLK);
      #1;
      iDval = 1'b0;
      iSOF  = 1'b0;
   endtask

   task automatic send_frame(input int kind, input int flat, input logic [1:0] pat,
                             input logic mode, input bit gap, input bit toggle);
      for (int y = 0; y < 6; y++) begin
         for (int x = 0; x < LW; x++) begin
            if (x == 0 && y == 0) begin
               iPattern = pat;
               iMode    = mode;
            end else if (toggle) begin
               iPattern = ~pat;
               iMode    = ~mode;
            end
            beat(pix(kind, flat, x, y), (x == 0 && y == 0));
            if (gap && ((x + y) % 3 == 0)) idle(2);
         end
      end
      iPattern = pat;
      iMode    = mode;
      idle(4);
   endtask

   task automatic test_reset();
      iRST_N = 1'b0; iData = '0; iDval = 1'b0; iSOF = 1'b0; iPattern = 2'b00; iMode = 1'b1;
      idle(3);
      tests++;
      if ({oRed, oGreen, oBlue} !== {3*DS{1'b0}} || oDval !== 1'b0 || oSOF !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: rgb=%0d/%0d/%0d dval=%b sof=%b, required all 0",
                  oRed, oGreen, oBlue, oDval, oSOF);
      end
      iRST_N = 1'b1;
      idle(2);
      clear_q();
      for (int i = 0; i < 48; i++) beat(100, 1'b0);
      idle(4);
      tests++;
      if (qr.size() !== 0) begin
         fails++;
         $display("FAIL no_sof_no_output: %0d pulses, required 0", qr.size());
      end
   endtask

   task automatic test_flat();
      clear_q();
      send_frame(0, 100, 2'b00, 1'b1, 1'b0, 1'b0);
      tests++;
      if (qr.size() !== 24) begin
         fails++;
         $display("FAIL flat_count: %0d pulses, required 24", qr.size());
      end
      for (int i = 0; i < qr.size(); i++) begin
         tests++;
         if (qr[i] !== 10'd100 || qg[i] !== 10'd100 || qb[i] !== 10'd100 || qs[i] !== (i == 0)) begin
            fails++;
            $display("FAIL flat_px%0d: rgb=%0d/%0d/%0d sof=%b, required 100/100/100 sof=%0d",
                     i, qr[i], qg[i], qb[i], qs[i], (i == 0));
         end
      end
   endtask

   task automatic test_rggb();
      for (int k = 0; k < 4; k++) begin
         logic [1:0] pat;
         logic [DS-1:0] er, eb;
         pat = (k < 2) ? 2'b00 : 2'b11;
         er  = (k < 2) ? 10'd400 : 10'd50;
         eb  = (k < 2) ? 10'd50 : 10'd400;
         clear_q();
         send_frame(1, 0, pat, k[0], 1'b0, 1'b0);
         tests++;
         if (qr.size() !== 24) begin
            fails++;
            $display("FAIL rggb_count k=%0d: %0d pulses, required 24", k, qr.size());
         end
         for (int i = 0; i < qr.size(); i++) begin
            tests++;
            if (qr[i] !== er || qg[i] !== 10'd200 || qb[i] !== eb) begin
               fails++;
               $display("FAIL rggb k=%0d px%0d: rgb=%0d/%0d/%0d, required %0d/200/%0d",
                        k, i, qr[i], qg[i], qb[i], er, eb);
            end
         end
      end
   endtask

   task automatic test_ramp();
      // Mode 1 on a linear ramp returns the centre value on every channel
      clear_q();
      send_frame(2, 0, 2'b00, 1'b1, 1'b0, 1'b1);
      tests++;
      if (qr.size() !== 24) begin
         fails++;
         $display("FAIL ramp1_count: %0d pulses, required 24", qr.size());
      end
      for (int i = 0; i < qr.size(); i++) begin
         int v;
         v = 10 * (i % 6 + 1) + 100 * (i / 6 + 1) + 5;
         tests++;
         if (qr[i] !== v[DS-1:0] || qg[i] !== v[DS-1:0] || qb[i] !== v[DS-1:0]) begin
            fails++;
            $display("FAIL ramp1 px%0d: rgb=%0d/%0d/%0d, required %0d each", i, qr[i], qg[i], qb[i], v);
         end
      end
      clear_q();
      send_frame(2, 0, 2'b00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < qr.size(); i++) begin
         int xc, yc, v, er, eg, eb;
         xc = i % 6 + 1; yc = i / 6 + 1;
         v  = 10 * xc + 100 * yc + 5;
         eg = v + 55;
         case ({yc[0], xc[0]})
            2'b00:   begin er = v;       eb = v + 110; end
            2'b01:   begin er = v + 10;  eb = v + 100; end
            2'b10:   begin er = v + 100; eb = v + 10;  end
            default: begin er = v + 110; eb = v;       end
         endcase
         tests++;
         if (qr[i] !== er[DS-1:0] || qg[i] !== eg[DS-1:0] || qb[i] !== eb[DS-1:0]) begin
            fails++;
            $display("FAIL ramp0 px%0d: rgb=%0d/%0d/%0d, required %0d/%0d/%0d",
                     i, qr[i], qg[i], qb[i], er, eg, eb);
         end
      end
      tests++;
      if (qr.size() !== 24) begin
         fails++;
         $display("FAIL ramp0_count: %0d pulses, required 24", qr.size());
      end
   endtask

   task automatic test_latency();
      iPattern = 2'b00; iMode = 1'b1;
      for (int i = 0; i < 18; i++) beat(100, (i == 0));
      iData = 10'd100; iDval = 1'b1; iSOF = 1'b0;
      @(posedge iCLK); #1;
      iDval = 1'b0;
      tests++;
      if (oDval !== 1'b0) begin
         fails++;
         $display("FAIL lat_edgeN: oDval=%b, required 0", oDval);
      end
      @(posedge iCLK); #1;
      tests++;
      if (oDval !== 1'b1 || oSOF !== 1'b1 || oRed !== 10'd100) begin
         fails++;
         $display("FAIL lat_edgeN1: dval=%b sof=%b red=%0d, required 1/1/100", oDval, oSOF, oRed);
      end
      for (int k = 0; k < 2; k++) begin
         @(posedge iCLK); #1;
         tests++;
         if (oDval !== 1'b0 || oSOF !== 1'b0) begin
            fails++;
            $display("FAIL lat_after%0d: dval=%b sof=%b, required 0/0", k, oDval, oSOF);
         end
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 28; i++) beat(100, (i == 0));
      idle(3);
      iData = 10'd100; iDval = 1'b1;
      iRST_N = 1'b0;
      #1;
      tests++;
      if ({oRed, oGreen, oBlue} !== {3*DS{1'b0}} || oDval !== 1'b0 || oSOF !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: rgb=%0d/%0d/%0d dval=%b sof=%b, required all 0",
                  oRed, oGreen, oBlue, oDval, oSOF);
      end
      @(posedge iCLK); #1;
      iDval = 1'b0;
      iRST_N = 1'b1;
      clear_q();
      for (int i = 0; i < 19; i++) beat(100, 1'b0);
      idle(4);
      tests++;
      if (qr.size() !== 0) begin
         fails++;
         $display("FAIL reset_mid_silent: %0d pulses, required 0", qr.size());
      end
      send_frame(0, 100, 2'b00, 1'b1, 1'b0, 1'b0);
      tests++;
      if (qr.size() !== 24 || qs[0] !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_restart: %0d pulses first_sof=%b, required 24/1",
                  qr.size(), (qs.size() > 0) ? qs[0] : 1'b0);
      end
   endtask

   task automatic test_pattern_toggle();
      clear_q();
      send_frame(0, 1023, 2'b00, 1'b1, 1'b0, 1'b1);
      tests++;
      if (qr.size() !== 24) begin
         fails++;
         $display("FAIL sat_count: %0d pulses, required 24", qr.size());
      end
      for (int i = 0; i < qr.size(); i++) begin
         tests++;
         if (qr[i] !== 10'd1023 || qg[i] !== 10'd1023 || qb[i] !== 10'd1023) begin
            fails++;
            $display("FAIL sat px%0d: rgb=%0d/%0d/%0d, required 1023 each", i, qr[i], qg[i], qb[i]);
         end
      end
      clear_q();
      send_frame(1, 0, 2'b00, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < qr.size(); i++) begin
         tests++;
         if (qr[i] !== 10'd400 || qg[i] !== 10'd200 || qb[i] !== 10'd50) begin
            fails++;
            $display("FAIL toggle px%0d: rgb=%0d/%0d/%0d, required 400/200/50", i, qr[i], qg[i], qb[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_q();
      iPattern = 2'b00; iMode = 1'b1;
      for (int i = 0; i < 20; i++) beat(100, (i == 0));
      send_frame(0, 300, 2'b00, 1'b1, 1'b1, 1'b0);
      tests++;
      if (qr.size() !== 26) begin
         fails++;
         $display("FAIL b2b_count: %0d pulses, required 26", qr.size());
      end
      for (int i = 0; i < qr.size(); i++) begin
         logic [DS-1:0] ev;
         logic          es;
         ev = (i < 2) ? 10'd100 : 10'd300;
         es = (i == 0) || (i == 2);
         tests++;
         if (qr[i] !== ev || qg[i] !== ev || qb[i] !== ev || qs[i] !== es) begin
            fails++;
            $display("FAIL b2b px%0d: rgb=%0d/%0d/%0d sof=%b, required %0d each sof=%b",
                     i, qr[i], qg[i], qb[i], qs[i], ev, es);
         end
      end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_rggb();
      test_ramp();
      test_latency();
      test_reset_midframe();
      test_pattern_toggle();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bayer_demosaic.md
BAYER_DEMOSAIC -- requirements
Module: bayer_demosaic

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 10, meaning the pixel and colour-channel width in bits.
REQ-002 SHALL have parameter LINE_WIDTH, default 640, meaning the number of pixels per input line and the line-buffer depth.
REQ-003 SHALL have port iCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port iRST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port iData, input, DATA_SIZE bits: raw Bayer pixel.
REQ-006 SHALL have port iDval, input, 1 bit: iData valid; one pixel accepted per cycle in which it is high.
REQ-007 SHALL have port iSOF, input, 1 bit: start of frame, qualified by iDval; marks pixel (0,0).
REQ-008 SHALL have port iPattern, input, 2 bits: CFA phase, 00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR.
REQ-009 SHALL have port iMode, input, 1 bit: 0 selects 2x2 interpolation, 1 selects 3x3 bilinear.
REQ-010 SHALL have ports oRed, oGreen, oBlue, output, DATA_SIZE bits each: interpolated pixel.
REQ-011 SHALL have port oDval, output, 1 bit: output pixel valid.
REQ-012 SHALL have port oSOF, output, 1 bit: high together with oDval on the first output pixel of a frame.

Function
REQ-013 SHALL keep an internal column counter X (0..LINE_WIDTH-1) and a 16-bit row counter Y, both advancing only on accepted beats.
REQ-014 Counter update rules SHALL be:
- X wraps to 0 after LINE_WIDTH-1, and Y increments on that wrap.
- Y saturates at 16'hFFFF.
- An accepted beat with iSOF=1 is pixel (0,0); the counters then continue from X=1, Y=0.
REQ-015 iPattern and iMode SHALL be sampled only on an accepted iSOF beat; changes mid-frame have no effect until the next iSOF.
REQ-016 SHALL hold the two previous lines in internal line buffers of depth LINE_WIDTH, written only on accepted beats; buffer contents are not reset.
REQ-017 SHALL form a 3x3 window on each accepted beat at (X,Y); the window centre C is pixel (X-1,Y-1).
REQ-018 SHALL produce an output only for beats with X>=2 and Y>=2, so the output frame is (LINE_WIDTH-2) x (rows-2) and border pixels are cropped.
REQ-019 Latency SHALL be fixed: oDval is high for exactly one cycle, 2 clocks after each qualifying accepting edge, independent of gaps in iDval.
REQ-020 The colour of C SHALL be determined from {Yc[0],Xc[0]} and the latched pattern.
REQ-021 Mode 1 (3x3 bilinear) SHALL compute:
- R site: R=C; G=(N+S+E+W)>>2; B=(NE+NW+SE+SW)>>2.
- B site: the mirror of the R site.
- G site on an R row: G=C; R=(E+W)>>1; B=(N+S)>>1.
- G site on a B row: the mirror of the G site on an R row.
REQ-022 Mode 0 (2x2) SHALL use the quad {C,E,S,SE}: R and B are the quad's R and B samples; G is the sum of the two G samples >>1.
REQ-023 SHALL form sums at DATA_SIZE+2 bits without overflow and truncate after the shift; results never exceed 2^DATA_SIZE-1.
REQ-024 oSOF SHALL be asserted with the oDval of centre (1,1), i.e. the output for beat (2,2).
REQ-025 When iSOF arrives mid-frame, SHALL restart the counters immediately; no output is produced until (2,2) of the new frame, and lines from the previous frame are treated as garbage.
REQ-026 When iDval is low, SHALL change no internal state except the output registers; oDval is then low.

Reset
REQ-027 While iRST_N=0, SHALL drive oRed, oGreen, oBlue to 0 and oDval, oSOF to 0.
REQ-028 While iRST_N=0, SHALL clear X, Y and the window registers, and load the latched pattern and mode with 00 and 1.
REQ-029 After reset release, SHALL produce no output until an accepted iSOF beat followed by reaching (2,2).

Verification
REQ-030 LINE_WIDTH=8, 8x6 flat frame all 100, iMode=1 -> exactly 24 oDval pulses, all channels 100, oSOF on the first pulse only.
REQ-031 RGGB frame with R=400, G=200, B=50, iPattern=00, in both modes -> every output R=400, G=200, B=50.
REQ-032 The REQ-031 frame with iPattern=11 -> outputs R=50, B=400, G=200.
REQ-033 Beat (2,2) accepted on edge N, then iDval low 3 cycles -> oDval high only in the cycle after edge N+1, with oSOF=1.
REQ-034 iRST_N pulsed low at beat (4,3) -> outputs zero at once; no oDval until a new iSOF and (2,2).
REQ-035 iPattern toggled mid-frame and all channels 1023 in mode 1 -> no effect until the next iSOF; outputs 1023 with no wrap.
